alu_sequencer: RTL

Multi-cycle issue/response controller on the driving side of the combinational ALU. Accepts one command per valid/ready handshake and decodes it into ALUop plus registered operands a/b. It captures the ALU result and zero flag, evaluates branch conditions, and returns a registered response over a second valid/ready handshake. It sits between the decode stage and the ALU and owns all ALUop generation.

---
 rtl/alu_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command sequencer driving a combinational ALU; define ALU_SEQ_OVF_EN to capture signed overflow
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic [15:0] req_imm,
  input  logic        req_use_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_illegal,
  output logic        rsp_overflow
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state;
  logic [3:0]  cmd;
  logic [3:0]  dec_op;
  logic [31:0] req_b;
  logic        req_ill;
  logic        cmd_ill;
  assign req_ill = req_cmd > 4'd8;
  assign cmd_ill = cmd > 4'd8;
  assign req_b   = req_use_imm ? {{16{req_imm[15]}}, req_imm} : req_rt;
  // command to ALUop: bit3 = compare, bit2 = logic; branches reuse SUB so the zero flag means equality
  assign dec_op = req_cmd == 4'd2 ? 4'b0100 :
                  req_cmd == 4'd3 ? 4'b0101 :
                  req_cmd == 4'd4 ? 4'b0110 :
                  req_cmd == 4'd5 ? 4'b0111 :
                  req_cmd == 4'd6 ? 4'b1000 :
                  (req_cmd == 4'd1 || req_cmd == 4'd7 || req_cmd == 4'd8) ? 4'b0001 : 4'b0000;
  // issue/response FSM with registered ALU operands and response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      cmd         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_taken   <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          alu_a     <= req_ill ? '0 : req_rs;
          alu_b     <= req_ill ? '0 : req_b;
          alu_op    <= dec_op;
          cmd       <= req_cmd;
          req_ready <= 1'b0;
          state     <= EXEC;
        end
        EXEC: begin
          rsp_result  <= cmd_ill ? '0 : alu_result;
          rsp_zero    <= alu_flag;
          rsp_taken   <= cmd == 4'd7 ? alu_flag : cmd == 4'd8 ? !alu_flag : 1'b0;
          rsp_illegal <= cmd_ill;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_SEQ_OVF_EN
  // signed overflow of ADD/SUB, judged from the operand and result sign bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_overflow <= 1'b0;
    else if (state == EXEC)
      rsp_overflow <= cmd == 4'd0 ? (alu_a[31] == alu_b[31] && alu_result[31] != alu_a[31]) :
                      cmd == 4'd1 ? (alu_a[31] != alu_b[31] && alu_result[31] != alu_a[31]) : 1'b0;
  end
`else
  assign rsp_overflow = 1'b0;
`endif
endmodule
